spi_master_xfer_engine: RTL

//  SPI master transfer engine: serialises one DATA_W-bit word per request onto

---
 rtl/spi_master_pkg.sv | 25 ++
 rtl/spi_sclk_gen.sv | 45 ++++
 rtl/spi_master_xfer_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master transfer engine: FSM states and the
// per-transfer configuration captured when a request is accepted.
package spi_master_pkg;

    localparam int MAX_DIV_W = 16;
    localparam int MAX_SS_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_e;

    // Fields are zero-extended to the package maxima so one type serves every
    // parameterisation of the engine.
    typedef struct packed {
        logic                 cpol;
        logic                 cpha;
        logic                 lsb;
        logic [MAX_DIV_W-1:0] div;
        logic [MAX_SS_W-1:0]  ss;
    } cfg_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for SCLK: strobes every div+1 enabled cycles and reports
// whether the upcoming strobe is a leading (even-numbered) SCLK edge.
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             pclk,
    input  logic             p_reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             strobe,
    output logic             lead
);

    logic [DIV_W:0] cnt_q, cnt_d;
    logic           phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        strobe  = en && (cnt_q == {1'b0, div});
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (strobe) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else if (en) begin
            cnt_d = cnt_q + {{DIV_W{1'b0}}, 1'b1};
        end
    end

    assign lead = ~phase_q;

    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_master_xfer_engine.sv
// SPI master transfer engine: one DATA_W-bit full-duplex word per accepted
// request, with per-transfer CPOL/CPHA/bit-order/divider and slave select.
module spi_master_xfer_engine
    import spi_master_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  NUM_SS = 4,
    parameter int  DIV_W  = 8,
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              pclk,
    input  logic              p_reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   tx_ss,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              abort,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    input  logic              mi,
    output logic              mo,
    output logic              n_mo_en,
    output logic              sclk_out,
    output logic              n_sclk_en,
    output logic [NUM_SS-1:0] n_ss_out,
    output logic              n_ss_en
);

    localparam int            TW       = $clog2(2 * DATA_W);
    localparam int            NW       = TW - 1;
    localparam logic [TW-1:0] LAST_TOG = TW'(2 * DATA_W - 1);
    localparam logic [NW-1:0] TOP_BIT  = NW'(DATA_W - 1);

    state_e              state_q, state_d;
    cfg_t                cfg_q, cfg_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [TW-1:0]       bcnt_q, bcnt_d;
    logic                rx_valid_q, rx_valid_d;
    logic                mo_q, mo_d;
    logic                sclk_q, sclk_d;
    logic                n_en_q, n_en_d;
    logic [NUM_SS-1:0]   n_ss_q, n_ss_d;

    logic                accept, strobe, lead, gen_clr, do_tog;
    logic [TW-1:0]       tog_idx;
    logic [NW-1:0]       bit_n, bit_nx;
    logic                cfg_unused;

    // Bit number n of the word maps to a physical position by bit order.
    function automatic logic [NW-1:0] bit_pos(input logic lsb, input logic [NW-1:0] n);
        return lsb ? n : TOP_BIT - n;
    endfunction

    assign accept  = tx_valid && (state_q == IDLE) && !abort;
    assign tog_idx = (state_q == SETUP) ? '0 : bcnt_q + TW'(1);
    assign bit_n   = tog_idx[TW-1:1];
    assign bit_nx  = bit_n + NW'(1);

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .pclk    (pclk),
        .p_reset (p_reset),
        .en      (state_q != IDLE),
        .clr     (gen_clr),
        .div     (cfg_q.div[DIV_W-1:0]),
        .strobe  (strobe),
        .lead    (lead)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        bcnt_d     = bcnt_q;
        rx_valid_d = 1'b0;
        mo_d       = mo_q;
        sclk_d     = sclk_q;
        n_en_d     = n_en_q;
        n_ss_d     = n_ss_q;
        gen_clr    = 1'b0;
        do_tog     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SETUP;
                    cfg_d.cpol = cfg_cpol;
                    cfg_d.cpha = cfg_cpha;
                    cfg_d.lsb  = cfg_lsb;
                    cfg_d.div  = MAX_DIV_W'(clk_div);
                    cfg_d.ss   = MAX_SS_W'(tx_ss);
                    tx_d       = tx_data;
                    rx_sh_d    = '0;
                    bcnt_d     = '0;
                    n_ss_d     = ~(NUM_SS'(1) << tx_ss);
                    n_en_d     = 1'b0;
                    sclk_d     = cfg_cpol;
                    mo_d       = cfg_cpha ? 1'b0 : (cfg_lsb ? tx_data[0] : tx_data[DATA_W-1]);
                    gen_clr    = 1'b1;
                end
            end
            SETUP: begin
                if (strobe) begin
                    do_tog  = 1'b1;
                    state_d = XFER;
                    bcnt_d  = '0;
                end
            end
            XFER: begin
                if (strobe) begin
                    if (bcnt_q == LAST_TOG) begin
                        state_d = HOLD;
                    end else begin
                        do_tog = 1'b1;
                        bcnt_d = tog_idx;
                    end
                end
            end
            HOLD: begin
                if (strobe) begin
                    state_d    = IDLE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    n_ss_d     = '1;
                    n_en_d     = 1'b1;
                    mo_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sample edges capture MISO; the other edges launch the next MOSI bit.
        // In CPHA=0 bit 0 is already on the line, so launches run one bit ahead.
        if (do_tog) begin
            sclk_d = ~sclk_q;
            if (lead ^ cfg_q.cpha) begin
                rx_sh_d[bit_pos(cfg_q.lsb, bit_n)] = mi;
            end else if (cfg_q.cpha) begin
                mo_d = tx_q[bit_pos(cfg_q.lsb, bit_n)];
            end else if (tog_idx != LAST_TOG) begin
                mo_d = tx_q[bit_pos(cfg_q.lsb, bit_nx)];
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            n_ss_d     = '1;
            n_en_d     = 1'b1;
            sclk_d     = cfg_q.cpol;
            mo_d       = 1'b0;
            rx_valid_d = 1'b0;
            rx_sh_d    = rx_sh_q;
            rx_data_d  = rx_data_q;
        end
    end

    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            bcnt_q     <= '0;
            rx_valid_q <= 1'b0;
            mo_q       <= 1'b0;
            sclk_q     <= 1'b0;
            n_en_q     <= 1'b1;
            n_ss_q     <= '1;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            bcnt_q     <= bcnt_d;
            rx_valid_q <= rx_valid_d;
            mo_q       <= mo_d;
            sclk_q     <= sclk_d;
            n_en_q     <= n_en_d;
            n_ss_q     <= n_ss_d;
        end
    end

    // Zero-extension bits of the captured config carry no information.
    assign cfg_unused = ^{cfg_q.div, cfg_q.ss};

    assign tx_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign mo        = mo_q;
    assign sclk_out  = sclk_q;
    assign n_ss_out  = n_ss_q;
    assign n_mo_en   = n_en_q;
    assign n_sclk_en = n_en_q;
    assign n_ss_en   = n_en_q;

endmodule
